// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester's access channel into the shared data-memory arbiter. Two
// instances are used: one for the pipeline MEM stage (cpu), one for the
// debug/loader port (dbg).
//
// Signals
//   req    requester -> arbiter  access request, held with its fields until gnt
//   we     requester -> arbiter  1=store, 0=load
//   sz     requester -> arbiter  00=byte, 01=half, 1x=word
//   addr   requester -> arbiter  byte address (ADDR_WIDTH bits)
//   wdata  requester -> arbiter  store data
//   gnt    arbiter -> requester  combinational; access happens at this edge
//   rvalid arbiter -> requester  registered; one cycle after a granted load
//   rdata  arbiter -> requester  registered load data, valid with rvalid
//   err    arbiter -> requester  only with DMEM_ARB_ALIGN_CHK_EN; one-cycle
//                                pulse after a granted misaligned access
//
// Modports: master = requester side, slave = arbiter side.
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req;
    logic                  we;
    logic [1:0]            sz;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic                  err;

    modport master (output req, we, sz, addr, wdata,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, sz, addr, wdata,
                    output gnt, rvalid, rdata, err);
`else
    modport master (output req, we, sz, addr, wdata,
                    input  gnt, rvalid, rdata);
    modport slave  (input  req, we, sz, addr, wdata,
                    output gnt, rvalid, rdata);
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single byte-addressed data memory between the pipeline MEM stage
// (cpu port) and the debug/loader port (dbg port). One access is granted per
// cycle and its fields are driven onto the dmem pins; load data is captured at
// the grant edge and returned with one cycle of latency.
//
// Arbitration: cpu has priority, except that dbg is forced through after
// STARVE_LIMIT consecutive cpu wins while dbg waits. A dbg grant with
// dbg_lock=1 keeps ownership on dbg (DBG_LOCK) until dbg releases the lock.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   cpu, dbg       dmem_arbiter_if.slave requester channels
//   dbg_lock       sampled with a granted dbg request; holds ownership on dbg
//   mem_addr/rd_en/wr_en/sz/din  to dmem (all zero when nothing is granted)
//   mem_dout       from dmem, combinational read data
//
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN
//   When defined, misaligned half/word accesses are granted but blocked from
//   dmem, flagged on <port>.err one cycle later, and loads return rdata=0.
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_arbiter_if.slave         cpu,
    dmem_arbiter_if.slave         dbg,
    input  logic                  dbg_lock,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [1:0]            mem_sz,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    typedef enum logic {
        ARB      = 1'b0,
        DBG_LOCK = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                cpu_gnt, dbg_gnt;
    logic                starved;
    logic                cpu_mis, dbg_mis;
    logic                sel_we, sel_mis;
    logic                cpu_rvalid_q, cpu_rvalid_d;
    logic                dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0]         cpu_rdata_q, cpu_rdata_d;
    logic [31:0]         dbg_rdata_q, dbg_rdata_d;

    assign starved = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic cpu_err_q, cpu_err_d;
    logic dbg_err_q, dbg_err_d;

    // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lsb);
        return ((sz == 2'b01) && lsb[0]) || (sz[1] && (lsb != 2'b00));
    endfunction

    assign cpu_mis = is_misaligned(cpu.sz, cpu.addr[1:0]);
    assign dbg_mis = is_misaligned(dbg.sz, dbg.addr[1:0]);

    assign cpu_err_d = cpu_gnt & cpu_mis;
    assign dbg_err_d = dbg_gnt & dbg_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_err_q <= 1'b0;
            dbg_err_q <= 1'b0;
        end else begin
            cpu_err_q <= cpu_err_d;
            dbg_err_q <= dbg_err_d;
        end
    end

    assign cpu.err = cpu_err_q;
    assign dbg.err = dbg_err_q;
`else
    assign cpu_mis = 1'b0;
    assign dbg_mis = 1'b0;
`endif

    // State register plus all other flops of the arbiter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            starve_cnt_q <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Next-state logic. Lock is released either at a dbg grant that drops the
    // lock, or when dbg goes idle and drops the lock at the same time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:      if (dbg_gnt && dbg_lock) state_d = DBG_LOCK;
            DBG_LOCK: if (!dbg_lock && (dbg_gnt || !dbg.req)) state_d = ARB;
            default:  state_d = ARB;
        endcase
    end

    // Output logic: grants. Held at zero during reset so no access can start.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst_n) begin
            case (state_q)
                ARB: begin
                    if (cpu.req && dbg.req) begin
                        if (starved) dbg_gnt = 1'b1;
                        else         cpu_gnt = 1'b1;
                    end else begin
                        cpu_gnt = cpu.req;
                        dbg_gnt = dbg.req;
                    end
                end
                DBG_LOCK: dbg_gnt = dbg.req;
                default: ;
            endcase
        end
    end

    // Starvation counter: counts cpu wins while dbg waits, saturating at the
    // limit so dbg stays forced until it is actually served.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (dbg_gnt || !dbg.req)   starve_cnt_d = '0;
        else if (cpu_gnt && !starved) starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // dmem pin mux: fields of the granted port, all zero when idle.
    always_comb begin
        mem_addr = '0;
        mem_sz   = '0;
        mem_din  = '0;
        sel_we   = 1'b0;
        sel_mis  = 1'b0;
        if (cpu_gnt) begin
            mem_addr = cpu.addr;
            mem_sz   = cpu.sz;
            mem_din  = cpu.wdata;
            sel_we   = cpu.we;
            sel_mis  = cpu_mis;
        end else if (dbg_gnt) begin
            mem_addr = dbg.addr;
            mem_sz   = dbg.sz;
            mem_din  = dbg.wdata;
            sel_we   = dbg.we;
            sel_mis  = dbg_mis;
        end
        mem_rd_en = (cpu_gnt | dbg_gnt) & ~sel_we & ~sel_mis;
        mem_wr_en = (cpu_gnt | dbg_gnt) &  sel_we & ~sel_mis;
    end

    // Load return: rdata only changes on a granted load so it holds between loads.
    always_comb begin
        cpu_rvalid_d = cpu_gnt & ~cpu.we;
        dbg_rvalid_d = dbg_gnt & ~dbg.we;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        if (cpu_rvalid_d) cpu_rdata_d = cpu_mis ? 32'h0 : mem_dout;
        if (dbg_rvalid_d) dbg_rdata_d = dbg_mis ? 32'h0 : mem_dout;
    end

    assign cpu.gnt    = cpu_gnt;
    assign cpu.rvalid = cpu_rvalid_q;
    assign cpu.rdata  = cpu_rdata_q;
    assign dbg.gnt    = dbg_gnt;
    assign dbg.rvalid = dbg_rvalid_q;
    assign dbg.rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A byte-array dmem model answers the
// arbiter's pins; a separate reference memory plus a small arbitration model
// (lock flag, count of dbg waits) predicts grants, dmem pins and load returns.
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN (enables alignment checks).
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;
    localparam int AW    = 12;
    localparam int LIMIT = 4;
    localparam int BW    = AW + 36;

    logic          clk;
    logic          rst_n;
    logic          dbg_lock;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [1:0]    mem_sz;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;
    logic          mem_init;

    dmem_arbiter_if #(.ADDR_WIDTH(AW)) cpu_if ();
    dmem_arbiter_if #(.ADDR_WIDTH(AW)) dbg_if ();

    dmem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT), .STARVE_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (cpu_if),
        .dbg      (dbg_if),
        .dbg_lock (dbg_lock),
        .mem_addr (mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en),
        .mem_sz   (mem_sz),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // dmem model driven by the DUT pins and a reference copy kept by the model.
    logic [7:0] dmem    [0:4095];
    logic [7:0] ref_mem [0:4095];

    function automatic logic [7:0] seed_byte(input int i);
        return 8'((i * 97) ^ (i >> 4) ^ 8'h5A);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    endfunction

    always_comb begin
        mem_dout = '0;
        for (int k = 0; k < 4; k++) mem_dout[8*k +: 8] = dmem[mem_addr + AW'(k)];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= seed_byte(i);
        end else if (mem_wr_en) begin
            for (int k = 0; k < 4; k++)
                if (k < nbytes(mem_sz)) dmem[mem_addr + AW'(k)] <= mem_din[8*k +: 8];
        end
    end

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[a + AW'(k)];
        return w;
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int k = 0; k < nbytes(sz); k++) ref_mem[a + AW'(k)] = d[8*k +: 8];
    endtask

`ifdef DMEM_ARB_ALIGN_CHK_EN
    function automatic logic misaligned(input logic [1:0] sz, input logic [AW-1:0] a);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction
`endif

    // Model state and expected / observed values of the current cycle.
    bit             m_locked;
    int             m_starve;
    logic           exp_cpu_gnt, exp_dbg_gnt, obs_cpu_gnt, obs_dbg_gnt;
    logic [BW-1:0]  exp_bus, obs_bus;
    logic           exp_cpu_rvalid, exp_dbg_rvalid, obs_cpu_rvalid, obs_dbg_rvalid;
    logic [31:0]    exp_cpu_rdata, exp_dbg_rdata, obs_cpu_rdata, obs_dbg_rdata;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic           exp_cpu_err, exp_dbg_err, obs_cpu_err, obs_dbg_err;
`endif
    int             total;
    int             bad;

    task automatic model_reset();
        m_locked       = 1'b0;
        m_starve       = 0;
        exp_cpu_gnt    = 1'b0;
        exp_dbg_gnt    = 1'b0;
        exp_cpu_rvalid = 1'b0;
        exp_dbg_rvalid = 1'b0;
        exp_cpu_rdata  = '0;
        exp_dbg_rdata  = '0;
    endtask

    task automatic applyStimulus(input bit to_dbg, input logic req, input logic we,
                                 input logic [1:0] sz, input logic [AW-1:0] addr,
                                 input logic [31:0] wdata);
        if (to_dbg) begin
            dbg_if.req = req; dbg_if.we = we; dbg_if.sz = sz; dbg_if.addr = addr; dbg_if.wdata = wdata;
        end else begin
            cpu_if.req = req; cpu_if.we = we; cpu_if.sz = sz; cpu_if.addr = addr; cpu_if.wdata = wdata;
        end
    endtask

    // One clock: predict from the current inputs, snapshot the combinational
    // outputs at the falling edge, then advance the model past the rising edge
    // and snapshot the registered outputs.
    task automatic run_cycle();
        logic c_req, c_we, d_req, d_we, lock, c_mis, d_mis;
        logic [1:0] c_sz, d_sz;
        logic [AW-1:0] c_addr, d_addr;
        logic [31:0] c_wd, d_wd;
        @(negedge clk);
        c_req = cpu_if.req; c_we = cpu_if.we; c_sz = cpu_if.sz; c_addr = cpu_if.addr; c_wd = cpu_if.wdata;
        d_req = dbg_if.req; d_we = dbg_if.we; d_sz = dbg_if.sz; d_addr = dbg_if.addr; d_wd = dbg_if.wdata;
        lock  = dbg_lock;
        c_mis = 1'b0;
        d_mis = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
        c_mis = misaligned(c_sz, c_addr);
        d_mis = misaligned(d_sz, d_addr);
`endif
        exp_cpu_gnt = 1'b0;
        exp_dbg_gnt = 1'b0;
        if (m_locked) exp_dbg_gnt = d_req;
        else if (c_req && d_req) begin
            if (m_starve >= LIMIT) exp_dbg_gnt = 1'b1;
            else                   exp_cpu_gnt = 1'b1;
        end else begin
            exp_cpu_gnt = c_req;
            exp_dbg_gnt = d_req;
        end
        if (exp_cpu_gnt)      exp_bus = {~c_we & ~c_mis, c_we & ~c_mis, c_sz, c_addr, c_wd};
        else if (exp_dbg_gnt) exp_bus = {~d_we & ~d_mis, d_we & ~d_mis, d_sz, d_addr, d_wd};
        else                  exp_bus = '0;
        obs_cpu_gnt = cpu_if.gnt;
        obs_dbg_gnt = dbg_if.gnt;
        obs_bus     = {mem_rd_en, mem_wr_en, mem_sz, mem_addr, mem_din};
        @(posedge clk);
        #1;
        exp_cpu_rvalid = exp_cpu_gnt && !c_we;
        exp_dbg_rvalid = exp_dbg_gnt && !d_we;
        if (exp_cpu_rvalid) exp_cpu_rdata = c_mis ? 32'h0 : ref_read(c_addr);
        if (exp_dbg_rvalid) exp_dbg_rdata = d_mis ? 32'h0 : ref_read(d_addr);
        if (exp_cpu_gnt && c_we && !c_mis) ref_write(c_addr, c_sz, c_wd);
        if (exp_dbg_gnt && d_we && !d_mis) ref_write(d_addr, d_sz, d_wd);
`ifdef DMEM_ARB_ALIGN_CHK_EN
        exp_cpu_err = exp_cpu_gnt && c_mis;
        exp_dbg_err = exp_dbg_gnt && d_mis;
        obs_cpu_err = cpu_if.err;
        obs_dbg_err = dbg_if.err;
`endif
        if (exp_dbg_gnt) m_locked = lock;
        else if (m_locked && !lock && !d_req) m_locked = 1'b0;
        if (exp_dbg_gnt || !d_req) m_starve = 0;
        else if (exp_cpu_gnt && m_starve < LIMIT) m_starve++;
        obs_cpu_rvalid = cpu_if.rvalid;
        obs_cpu_rdata  = cpu_if.rdata;
        obs_dbg_rvalid = dbg_if.rvalid;
        obs_dbg_rdata  = dbg_if.rdata;
    endtask

    task automatic idle_all();
        applyStimulus(0, 1'b0, 1'b0, 2'b00, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, 2'b00, '0, '0);
        dbg_lock = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(0, 1'b1, 1'b1, 2'b10, 12'h020, 32'h1111_1111);
        applyStimulus(1, 1'b1, 1'b1, 2'b10, 12'h024, 32'h2222_2222);
        rst_n    = 1'b0;
        mem_init = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cpu_if.gnt, dbg_if.gnt} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_gnt got=%b exp=00", {cpu_if.gnt, dbg_if.gnt});
        end
        total++;
        if ({mem_rd_en, mem_wr_en} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_mem_en got=%b exp=00", {mem_rd_en, mem_wr_en});
        end
        total++;
        if ({cpu_if.rvalid, dbg_if.rvalid} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_rvalid got=%b exp=00", {cpu_if.rvalid, dbg_if.rvalid});
        end
        total++;
        if ({cpu_if.rdata, dbg_if.rdata} !== 64'h0) begin
            bad++; $display("[TB] FAIL reset_rdata got=%h exp=0", {cpu_if.rdata, dbg_if.rdata});
        end
        mem_init = 1'b0;
        idle_all();
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_cpu_store_load();
        applyStimulus(0, 1'b1, 1'b1, 2'b10, 12'h010, 32'hDEAD_BEEF);
        run_cycle();
        total++;
        if (obs_cpu_gnt !== 1'b1 || obs_bus !== exp_bus) begin
            bad++; $display("[TB] FAIL store_gnt got=%b/%h exp=1/%h", obs_cpu_gnt, obs_bus, exp_bus);
        end
        applyStimulus(0, 1'b1, 1'b0, 2'b10, 12'h010, 32'h0);
        run_cycle();
        total++;
        if (obs_cpu_gnt !== 1'b1 || obs_bus !== exp_bus) begin
            bad++; $display("[TB] FAIL load_gnt got=%b/%h exp=1/%h", obs_cpu_gnt, obs_bus, exp_bus);
        end
        total++;
        if (obs_cpu_rvalid !== 1'b1 || obs_cpu_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("[TB] FAIL load_data got=%b/%h exp=1/deadbeef", obs_cpu_rvalid, obs_cpu_rdata);
        end
        applyStimulus(0, 1'b0, 1'b0, 2'b00, '0, '0);
        run_cycle();
        total++;
        if (obs_cpu_rvalid !== 1'b0 || obs_cpu_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("[TB] FAIL load_hold got=%b/%h exp=0/deadbeef", obs_cpu_rvalid, obs_cpu_rdata);
        end
    endtask

    task automatic test_starvation();
        logic pat;
        idle_all();
        run_cycle();
        applyStimulus(0, 1'b1, 1'b1, 2'b10, 12'h100, 32'hA5A5_0000);
        applyStimulus(1, 1'b1, 1'b1, 2'b00, 12'h200, 32'h0000_005A);
        for (int i = 0; i < 15; i++) begin
            run_cycle();
            pat = ((i % 5) != 4);
            total++;
            if ({obs_cpu_gnt, obs_dbg_gnt} !== {pat, ~pat}) begin
                bad++; $display("[TB] FAIL starve_pattern cyc=%0d got=%b exp=%b", i, {obs_cpu_gnt, obs_dbg_gnt}, {pat, ~pat});
            end
            total++;
            if (obs_bus !== exp_bus) begin
                bad++; $display("[TB] FAIL starve_bus cyc=%0d got=%h exp=%h", i, obs_bus, exp_bus);
            end
        end
    endtask

    task automatic test_dbg_lock_burst();
        int  waited;
        bit  got;
        idle_all();
        run_cycle();
        applyStimulus(0, 1'b1, 1'b1, 2'b10, 12'h300, 32'h1234_5678);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1, 1'b1, 1'b1, 2'b10, 12'h400 + AW'(4 * b), 32'hD0D0_0000 + 32'(b));
            dbg_lock = (b < 2);
            got    = 1'b0;
            waited = 0;
            while (!got && waited < 8) begin
                run_cycle();
                waited++;
                got = obs_dbg_gnt;
                total++;
                if ({obs_cpu_gnt, obs_dbg_gnt, obs_bus} !== {exp_cpu_gnt, exp_dbg_gnt, exp_bus}) begin
                    bad++; $display("[TB] FAIL burst_bus beat=%0d got=%h exp=%h", b,
                                    {obs_cpu_gnt, obs_dbg_gnt, obs_bus}, {exp_cpu_gnt, exp_dbg_gnt, exp_bus});
                end
            end
            total++;
            if (!got || waited != ((b == 0) ? LIMIT + 1 : 1)) begin
                bad++; $display("[TB] FAIL burst_beat beat=%0d got_gnt=%b waited=%0d exp_waited=%0d",
                                b, got, waited, (b == 0) ? LIMIT + 1 : 1);
            end
        end
        applyStimulus(1, 1'b0, 1'b0, 2'b00, '0, '0);
        dbg_lock = 1'b0;
        run_cycle();
        total++;
        if (obs_cpu_gnt !== 1'b1) begin
            bad++; $display("[TB] FAIL burst_cpu_after got=%b exp=1", obs_cpu_gnt);
        end
    endtask

    task automatic test_lock_hold();
        idle_all();
        applyStimulus(1, 1'b1, 1'b0, 2'b10, 12'h400, 32'h0);
        dbg_lock = 1'b1;
        run_cycle();
        total++;
        if (obs_dbg_gnt !== 1'b1 || obs_dbg_rvalid !== 1'b1 || obs_dbg_rdata !== 32'hD0D0_0000) begin
            bad++; $display("[TB] FAIL hold_dbg_load got=%b/%b/%h exp=1/1/d0d00000", obs_dbg_gnt, obs_dbg_rvalid, obs_dbg_rdata);
        end
        applyStimulus(0, 1'b1, 1'b0, 2'b10, 12'h300, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 2'b00, '0, '0);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            total++;
            if (obs_cpu_gnt !== 1'b0 || obs_bus !== '0) begin
                bad++; $display("[TB] FAIL hold_cpu_blocked cyc=%0d got=%b/%h exp=0/0", i, obs_cpu_gnt, obs_bus);
            end
        end
        dbg_lock = 1'b0;
        run_cycle();
        total++;
        if (obs_cpu_gnt !== 1'b0) begin
            bad++; $display("[TB] FAIL hold_release_cycle got=%b exp=0", obs_cpu_gnt);
        end
        run_cycle();
        total++;
        if (obs_cpu_gnt !== 1'b1 || obs_cpu_rvalid !== 1'b1 || obs_cpu_rdata !== 32'h1234_5678) begin
            bad++; $display("[TB] FAIL hold_cpu_after got=%b/%b/%h exp=1/1/12345678", obs_cpu_gnt, obs_cpu_rvalid, obs_cpu_rdata);
        end
        idle_all();
    endtask

    task automatic test_align();
        idle_all();
        applyStimulus(0, 1'b1, 1'b0, 2'b10, 12'h013, 32'h0);
        run_cycle();
`ifdef DMEM_ARB_ALIGN_CHK_EN
        total++;
        if (obs_cpu_gnt !== 1'b1 || obs_bus[BW-1] !== 1'b0) begin
            bad++; $display("[TB] FAIL align_rd_en got=%b/%b exp=1/0", obs_cpu_gnt, obs_bus[BW-1]);
        end
        total++;
        if ({obs_cpu_err, obs_cpu_rvalid} !== 2'b11 || obs_cpu_rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL align_err got=%b/%b/%h exp=1/1/0", obs_cpu_err, obs_cpu_rvalid, obs_cpu_rdata);
        end
        applyStimulus(0, 1'b1, 1'b1, 2'b01, 12'h021, 32'hFFFF_FFFF);
        run_cycle();
        total++;
        if (obs_bus[BW-2] !== 1'b0 || {obs_cpu_err, obs_cpu_rvalid} !== 2'b10) begin
            bad++; $display("[TB] FAIL align_half_store got=%b/%b/%b exp=0/1/0", obs_bus[BW-2], obs_cpu_err, obs_cpu_rvalid);
        end
        applyStimulus(0, 1'b0, 1'b0, 2'b00, '0, '0);
        run_cycle();
        total++;
        if (obs_cpu_err !== 1'b0) begin
            bad++; $display("[TB] FAIL align_err_pulse got=%b exp=0", obs_cpu_err);
        end
`else
        total++;
        if (obs_cpu_gnt !== 1'b1 || obs_bus[BW-1] !== 1'b1) begin
            bad++; $display("[TB] FAIL unaligned_rd_en got=%b/%b exp=1/1", obs_cpu_gnt, obs_bus[BW-1]);
        end
        total++;
        if (obs_cpu_rvalid !== 1'b1 || obs_cpu_rdata !== ref_read(12'h013)) begin
            bad++; $display("[TB] FAIL unaligned_data got=%b/%h exp=1/%h", obs_cpu_rvalid, obs_cpu_rdata, ref_read(12'h013));
        end
        applyStimulus(0, 1'b0, 1'b0, 2'b00, '0, '0);
        run_cycle();
`endif
    endtask

    task automatic test_back_to_back();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!cpu_if.req || exp_cpu_gnt)
                applyStimulus(0, $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
                              AW'($urandom), $urandom);
            if (!dbg_if.req || exp_dbg_gnt)
                applyStimulus(1, $urandom_range(0, 1) != 0, 1'($urandom), 2'($urandom),
                              AW'($urandom), $urandom);
            dbg_lock = ($urandom_range(0, 3) == 0);
            run_cycle();
            total++;
            if ({obs_cpu_gnt, obs_dbg_gnt, obs_bus} !== {exp_cpu_gnt, exp_dbg_gnt, exp_bus}) begin
                bad++; $display("[TB] FAIL rand_bus cyc=%0d got=%h exp=%h", cyc,
                                {obs_cpu_gnt, obs_dbg_gnt, obs_bus}, {exp_cpu_gnt, exp_dbg_gnt, exp_bus});
            end
            total++;
            if ({obs_cpu_rvalid, obs_cpu_rdata, obs_dbg_rvalid, obs_dbg_rdata} !==
                {exp_cpu_rvalid, exp_cpu_rdata, exp_dbg_rvalid, exp_dbg_rdata}) begin
                bad++; $display("[TB] FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc,
                                {obs_cpu_rvalid, obs_cpu_rdata, obs_dbg_rvalid, obs_dbg_rdata},
                                {exp_cpu_rvalid, exp_cpu_rdata, exp_dbg_rvalid, exp_dbg_rdata});
            end
`ifdef DMEM_ARB_ALIGN_CHK_EN
            total++;
            if ({obs_cpu_err, obs_dbg_err} !== {exp_cpu_err, exp_dbg_err}) begin
                bad++; $display("[TB] FAIL rand_err cyc=%0d got=%b exp=%b", cyc,
                                {obs_cpu_err, obs_dbg_err}, {exp_cpu_err, exp_dbg_err});
            end
`endif
        end
        idle_all();
        run_cycle();
    endtask

    task automatic test_reset_mid();
        idle_all();
        applyStimulus(1, 1'b1, 1'b0, 2'b10, 12'h300, 32'h0);
        dbg_lock = 1'b1;
        run_cycle();
        total++;
        if (obs_dbg_rvalid !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_pending got=%b exp=1", obs_dbg_rvalid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (dbg_if.rvalid !== 1'b0 || dbg_if.rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL mid_drop got=%b/%h exp=0/0", dbg_if.rvalid, dbg_if.rdata);
        end
        applyStimulus(0, 1'b1, 1'b0, 2'b10, 12'h300, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 2'b00, '0, '0);
        #2;
        rst_n = 1'b1;
        model_reset();
        run_cycle();
        total++;
        if (obs_cpu_gnt !== 1'b1 || obs_bus !== exp_bus) begin
            bad++; $display("[TB] FAIL mid_unlock got=%b/%h exp=1/%h", obs_cpu_gnt, obs_bus, exp_bus);
        end
        total++;
        if (obs_cpu_rvalid !== 1'b1 || obs_cpu_rdata !== exp_cpu_rdata) begin
            bad++; $display("[TB] FAIL mid_cpu_load got=%b/%h exp=1/%h", obs_cpu_rvalid, obs_cpu_rdata, exp_cpu_rdata);
        end
        idle_all();
        run_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total    = 0;
        bad      = 0;
        clk      = 1'b0;
        rst_n    = 1'b1;
        mem_init = 1'b1;
        idle_all();
        for (int i = 0; i < 4096; i++) ref_mem[i] = seed_byte(i);
        model_reset();
        test_reset();
        test_cpu_store_load();
        test_starvation();
        test_dbg_lock_burst();
        test_lock_hold();
        test_align();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
